lfsr_checker: RTL and testbench

- Receive end of the 16-bit noise LFSR bitstream: consumes one serial bit per valid cycle, self-synchronises to the sequence, then predicts and checks every following bit.
- Reports lock status, error pulses and a saturating error count, and rebuilds 16-bit words for comparison with the generator's parallel data output.
- Used in the noise path for BIST and for verifying the noise generator in silicon.

---
 rtl/lfsr_checker.sv | 144 ++++++++++++++
 tb/tb_lfsr_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit noise LFSR bitstream: self-synchronises, predicts each
// following bit, reports lock, errors and a saturating error count, and rebuilds 16-bit words.
module lfsr_checker #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'h002D,
  parameter int              LOCK_THRESH = 32,
  parameter int              LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
  localparam int BAD_W  = $clog2(LOSS_THRESH + 1);
  localparam int IDX_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_FILL,
    S_VERIFY,
    S_LOCKED
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   window_q;
  logic [FILL_W-1:0]  fill_q;
  logic [GOOD_W-1:0]  good_q;
  logic [BAD_W-1:0]   bad_q;
  logic [IDX_W-1:0]   idx_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [15:0]        err_count_q;
  logic [WIDTH-1:0]   word_q;
  logic               word_valid_q;

  logic [WIDTH-1:0]   window_d;
  logic               mismatch;
  logic [15:0]        err_count_d;

  // New bits enter at the top so window_q[0] is always the oldest bit, as in the generator.
  always_comb begin
    window_d    = {bit_in, window_q[WIDTH-1:1]};
    mismatch    = bit_in ^ (^(window_q & TAPS));
    err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
  end

  // NOTE: all state below is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FILL;
      window_q     <= '0;
      fill_q       <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      idx_q        <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      err_pulse_q  <= 1'b0;
      word_valid_q <= 1'b0;
      if (clear_errs) err_count_q <= '0;

      if (bit_valid) begin
        window_q <= window_d;
        case (state_q)
          S_FILL: begin
            if (fill_q == FILL_W'(WIDTH - 1)) begin
              fill_q <= '0;
              // An all-zero window is the LFSR lock-up state and can never be tracked.
              if (window_d != '0) begin
                state_q <= S_VERIFY;
                good_q  <= '0;
              end
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end

          S_VERIFY: begin
            if (mismatch) begin
              state_q <= S_FILL;
              fill_q  <= '0;
            end else if (good_q == GOOD_W'(LOCK_THRESH - 1)) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
              good_q   <= '0;
              bad_q    <= '0;
              idx_q    <= '0;
            end else begin
              good_q <= good_q + 1'b1;
            end
          end

          S_LOCKED: begin
            // The window already holds the group in word order once the last bit shifts in.
            if (idx_q == IDX_W'(WIDTH - 1)) begin
              idx_q        <= '0;
              word_q       <= window_d;
              word_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end

            if (mismatch) begin
              err_pulse_q <= 1'b1;
              if (!clear_errs) err_count_q <= err_count_d;
              if (bad_q == BAD_W'(LOSS_THRESH - 1)) begin
                state_q  <= S_FILL;
                locked_q <= 1'b0;
                fill_q   <= '0;
                bad_q    <= '0;
              end else begin
                bad_q <= bad_q + 1'b1;
              end
            end else begin
              bad_q <= '0;
            end
          end

          default: state_q <= S_FILL;
        endcase
      end
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a reference LFSR drives the serial stream and a bit-history model
// of the checker supplies every expected output.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_errs;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] word_out;
  logic        word_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clear_errs (clear_errs),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  // Reference generator: gen[0] is the bit emitted next.
  bit gen[$];

  task automatic gen_seed(input logic [15:0] s);
    gen.delete();
    for (int i = 0; i < 16; i++) gen.push_back(s[i]);
  endtask

  function automatic bit gen_next();
    bit o;
    o = gen[0];
    gen.push_back(gen[0] ^ gen[2] ^ gen[3] ^ gen[5]);
    void'(gen.pop_front());
    return o;
  endfunction

  // Checker model: last 16 received bits, mode, run lengths and the current word group.
  localparam int M_FILL = 0, M_VERIFY = 1, M_LOCKED = 2;
  int          m_mode, m_fill, m_good, m_bad;
  bit          m_win[$];
  bit          m_grp[$];
  logic        e_locked, e_pulse, e_wv;
  logic [15:0] e_cnt, e_word;
  logic [15:0] ref_words[$];
  logic [15:0] last_words[$];

  task automatic model_reset();
    m_win.delete();
    for (int i = 0; i < 16; i++) m_win.push_back(1'b0);
    m_grp.delete();
    m_mode = M_FILL; m_fill = 0; m_good = 0; m_bad = 0;
    e_locked = 0; e_pulse = 0; e_wv = 0; e_cnt = 0; e_word = 0;
  endtask

  task automatic model_step(input bit b, input bit clr);
    bit pred, mis, all_zero;
    pred = m_win[0] ^ m_win[2] ^ m_win[3] ^ m_win[5];
    mis  = (b != pred);
    m_win.push_back(b);
    void'(m_win.pop_front());
    e_pulse = 0;
    e_wv    = 0;
    if (clr) e_cnt = 0;
    case (m_mode)
      M_FILL: begin
        m_fill++;
        if (m_fill == 16) begin
          m_fill   = 0;
          all_zero = 1;
          foreach (m_win[i]) if (m_win[i]) all_zero = 0;
          if (!all_zero) begin m_mode = M_VERIFY; m_good = 0; end
        end
      end
      M_VERIFY: begin
        if (mis) begin
          m_mode = M_FILL; m_fill = 0;
        end else begin
          m_good++;
          if (m_good == 32) begin
            m_mode = M_LOCKED; e_locked = 1; m_bad = 0; m_grp.delete();
          end
        end
      end
      default: begin
        m_grp.push_back(b);
        if (m_grp.size() == 16) begin
          for (int k = 0; k < 16; k++) e_word[k] = m_grp[k];
          e_wv = 1;
          last_words.push_back(e_word);
          m_grp.delete();
        end
        if (mis) begin
          e_pulse = 1;
          if (!clr && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
          m_bad++;
          if (m_bad == 4) begin e_locked = 0; m_mode = M_FILL; m_fill = 0; end
        end else begin
          m_bad = 0;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".locked"},     {31'd0, locked},     {31'd0, e_locked});
    check({tag, ".err_pulse"},  {31'd0, err_pulse},  {31'd0, e_pulse});
    check({tag, ".err_count"},  {16'd0, err_count},  {16'd0, e_cnt});
    check({tag, ".word_out"},   {16'd0, word_out},   {16'd0, e_word});
    check({tag, ".word_valid"}, {31'd0, word_valid}, {31'd0, e_wv});
  endtask

  // Optional idle cycles first, then one accepted bit; outputs sampled 1 time unit after the edge.
  task automatic send(input string tag, input bit b, input int gap = 0, input bit clr = 0);
    for (int g = 0; g < gap; g++) begin
      bit_valid  = 1'b0;
      clear_errs = 1'b0;
      @(posedge clk); #1;
      e_pulse = 0;
      e_wv    = 0;
      check_outputs({tag, ".idle"});
    end
    bit_in     = b;
    bit_valid  = 1'b1;
    clear_errs = clr;
    @(posedge clk); #1;
    model_step(b, clr);
    check_outputs(tag);
    bit_valid  = 1'b0;
    clear_errs = 1'b0;
  endtask

  task automatic do_reset();
    bit_valid  = 1'b0;
    clear_errs = 1'b0;
    reset_n    = 1'b0;
    #1;
    model_reset();
    last_words.delete();
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic lock_stream(input string tag, input int gap);
    for (int n = 1; n <= 48; n++) begin
      send(tag, gen_next(), gap);
      if (n == 47) check({tag, ".pre_lock"}, {31'd0, locked}, 32'd0);
      if (n == 48) check({tag, ".lock_at_48"}, {31'd0, locked}, 32'd1);
    end
  endtask

  initial begin
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    clear_errs = 1'b0;
    reset_n    = 1'b1;
    #2;

    // Gap-free lock from the reference seed; first word 16 bits after lock.
    do_reset();
    gen_seed(16'hACE1);
    lock_stream("lock", 0);
    check("lock.err_count", {16'd0, err_count}, 32'd0);
    for (int n = 49; n <= 112; n++) begin
      send("lock.run", gen_next());
      if (n == 63) check("lock.word_early", {31'd0, word_valid}, 32'd0);
      if (n == 64) check("lock.first_word", {31'd0, word_valid}, 32'd1);
    end
    ref_words = last_words;

    // Same stream with one valid cycle in three: identical lock point and words.
    do_reset();
    gen_seed(16'hACE1);
    lock_stream("gap", 2);
    for (int n = 49; n <= 112; n++) send("gap.run", gen_next(), 2);
    check("gap.word_count", last_words.size(), ref_words.size());
    foreach (ref_words[i])
      if (i < last_words.size()) check("gap.word_seq", {16'd0, last_words[i]}, {16'd0, ref_words[i]});

    // Single flipped bit after lock, random seed and random gaps.
    do_reset();
    gen_seed(16'($urandom_range(1, 16'hFFFF)));
    lock_stream("flip", 0);
    for (int n = 0; n < 5; n++) send("flip.pre", gen_next(), $urandom_range(0, 2));
    send("flip.bad", ~gen_next());
    check("flip.pulse", {31'd0, err_pulse}, 32'd1);
    check("flip.count1", {16'd0, err_count}, 32'd1);
    for (int n = 0; n < 20; n++) send("flip.after", gen_next(), $urandom_range(0, 2));
    check("flip.count5", {16'd0, err_count}, 32'd5);
    check("flip.held", {31'd0, locked}, 32'd1);

    // Four consecutive inverted bits drop lock; the clean stream relocks after 48 bits.
    for (int n = 1; n <= 4; n++) begin
      send("loss.bad", ~gen_next());
      if (n == 3) check("loss.still", {31'd0, locked}, 32'd1);
      if (n == 4) check("loss.drop", {31'd0, locked}, 32'd0);
    end
    lock_stream("relock", 0);

    // All-zero stream: FILL repeats and nothing is ever flagged.
    do_reset();
    for (int n = 0; n < 64; n++) send("zeros", 1'b0);
    check("zeros.locked", {31'd0, locked}, 32'd0);
    check("zeros.count", {16'd0, err_count}, 32'd0);

    // Saturation from a preloaded count, then clear_errs colliding with an error.
    do_reset();
    gen_seed(16'hBEEF);
    lock_stream("sat", 0);
    for (int n = 0; n < 3; n++) send("sat.pre", gen_next());
    force dut.err_count_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.err_count_q;
    e_cnt = 16'hFFFE;
    check("sat.preload", {16'd0, err_count}, 32'h0000FFFE);
    send("sat.err", ~gen_next());
    check("sat.ffff", {16'd0, err_count}, 32'h0000FFFF);
    for (int n = 0; n < 20; n++) send("sat.hold", gen_next());
    check("sat.held", {16'd0, err_count}, 32'h0000FFFF);
    send("clr.err", ~gen_next(), 0, 1'b1);
    check("clr.count", {16'd0, err_count}, 32'd0);
    check("clr.pulse", {31'd0, err_pulse}, 32'd1);
    for (int n = 0; n < 20; n++) send("clr.after", gen_next());

    // Asynchronous reset mid-word while locked, then a clean relock.
    do_reset();
    gen_seed(16'($urandom_range(1, 16'hFFFF)));
    lock_stream("arst", 0);
    for (int n = 0; n < 23; n++) send("arst.pre", gen_next());
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst.async");
    @(negedge clk);
    reset_n = 1'b1;
    lock_stream("arst.relock", 0);

    // Random gaps and sparse random bit errors, all against the model.
    do_reset();
    gen_seed(16'($urandom_range(1, 16'hFFFF)));
    for (int n = 0; n < 400; n++) begin
      bit b;
      b = gen_next();
      if ($urandom_range(0, 39) == 0) b = ~b;
      send("rand", b, $urandom_range(0, 1), 1'($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
